// File: rtl/resta_serial_4bits_if.sv
// Operand/result bundle for the bit-serial subtractor: request side drives
// the operands and start, the subtractor returns handshake and difference.
interface resta_serial_4bits_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic [WIDTH:0]   DT;

  modport master (
    output start, A, B, Bin,
    input  busy, done, D, Bout, DT
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, Bout, DT
  );
endinterface

// File: rtl/resta_serial_4bits.sv
// Bit-serial D = A - B - Bin using one full-subtractor cell and a registered
// borrow; start/busy/done framing, results held until the next completion.
module resta_serial_4bits #(
  parameter int unsigned WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  resta_serial_4bits_if.slave  bus
);
  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;
  logic             d_bit;
  logic             br_next;

  always_comb begin
    d_bit   = a_sr[0] ^ b_sr[0] ^ br;
    br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      d_q    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.A;
            b_sr   <= bus.B;
            br     <= bus.Bin;
            res    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_next;
          res  <= {d_bit, res[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          // Final bit: publish the assembled difference directly, bypassing res.
          if (cnt == LAST) begin
            d_q    <= {d_bit, res[WIDTH-1:1]};
            bout_q <= br_next;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
  assign bus.DT   = {bout_q, d_q};
endmodule

// File: doc/resta_serial_4bits.md
# resta_serial_4bits

Bit-serial 4-bit subtractor and the inverse companion of the lab's combinational ripple adder. It computes D = A − B − Bin one bit per clock using a single full-subtractor cell and a registered borrow. A start/busy/done handshake frames each operation. The outputs mirror the adder's result format (S/ST/Cout becomes D/DT/Bout), so the same exhaustive checking strategy applies.

## Interface
- WIDTH, 4, operand width; the test plan is written for 4.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- A  in  WIDTH  minuend, captured when start is accepted
- B  in  WIDTH  subtrahend, captured when start is accepted
- Bin  in  1  borrow-in, captured when start is accepted
- busy  out  1  high while bits are being processed (SHIFT)
- done  out  1  one-cycle pulse, result valid
- D  out  WIDTH  difference bits
- Bout  out  1  borrow-out; 1 iff A < B + Bin (unsigned)
- DT  out  WIDTH+1  {Bout, D} = (A − B − Bin) mod 2^(WIDTH+1)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 loads A, B, Bin into operand shift registers and the borrow flop, and clears the bit counter.
  - Goes to SHIFT.
- SHIFT: each edge consumes the LSBs a0, b0 and borrow br.
  - d = a0 ^ b0 ^ br
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d shifts into the MSB of the result register; the operand registers shift right; the counter increments.
  - On the edge that processes bit WIDTH−1: D is loaded with the completed result, Bout is loaded with the final br', and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally returns to IDLE.
- start while busy or in DONE is ignored; it is neither queued nor restarts the operation.
- Changes to A, B or Bin after acceptance have no effect on the running operation.
- D, Bout and DT hold the last completed result until the next completion. They are not cleared at start.
- DT is purely combinational from D and Bout: DT = {Bout, D}.
- Arithmetic is unsigned modulo 2^WIDTH; a borrow appears only in Bout. No signed-overflow flag.

## Timing
- Reset (async, on assertion): state=IDLE, busy=0, done=0, D=0, Bout=0, DT=0; all internal registers cleared.
- Reset mid-operation: the operation is aborted with no done pulse and outputs go to 0. The first start after rst deasserts is accepted normally.
- Start accepted at edge 0; busy=1 from edge 0 through edge WIDTH.
- D, Bout and done update at edge WIDTH; done falls at edge WIDTH+1.
- Latency is WIDTH cycles from start acceptance to done.
- Throughput: one operation per WIDTH+2 cycles. The earliest next start is sampled in the IDLE cycle following DONE.
- busy and done are never high in the same cycle.

## Test plan
- Reset: assert rst asynchronously between edges -> busy=0, done=0, D=0, Bout=0, DT=5'h00 immediately; hold with start=0 -> nothing changes.
- A=9, B=3, Bin=0, 1-cycle start -> busy for 4 cycles, then done for 1 cycle with D=4'h6, Bout=0, DT=5'h06.
- A=3, B=9, Bin=0 -> D=4'hA, Bout=1, DT=5'h1A.
- Boundaries:
  - A=0, B=0, Bin=1 -> D=4'hF, Bout=1.
  - A=15, B=15, Bin=1 -> D=4'hF, Bout=1.
  - A=15, B=0, Bin=0 -> D=4'hF, Bout=0.
- Start A=7, B=2, Bin=0; two cycles later drive A=0 and pulse start again -> exactly one done, D=4'h5, Bout=0. Outputs hold 5 until the next operation completes.
- Assert rst in the 2nd SHIFT cycle of A=12, B=5 -> no done, outputs 0. Then sweep all 512 (A, B, Bin) combinations -> DT equals (A − B − Bin) mod 32 every time; $fatal on the first mismatch.
